// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port SRAM among NR_PORTS requesters.
// Supports per-port grant lock and routes each 1-cycle read response back to its requester.
module mem_port_arbiter #(
  parameter int unsigned NR_PORTS   = 2,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 10
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_PORTS-1:0]            req_i,
  input  logic [NR_PORTS-1:0]            lock_i,
  input  logic [NR_PORTS-1:0]            we_i,
  input  logic [NR_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_PORTS*USER_WIDTH-1:0] wuser_i,
  output logic [NR_PORTS-1:0]            gnt_o,
  output logic [NR_PORTS-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [USER_WIDTH-1:0]          ruser_o,
  output logic                           req_o,
  output logic                           we_o,
  output logic [ADDR_WIDTH-1:0]          addr_o,
  output logic [DATA_WIDTH/8-1:0]        be_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic [USER_WIDTH-1:0]          user_o,
  input  logic [DATA_WIDTH-1:0]          data_i,
  input  logic [USER_WIDTH-1:0]          user_i
);

  localparam int unsigned IdxW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned BeW  = DATA_WIDTH / 8;

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic            locked_q, locked_d;
  logic            rd_pend_q, rd_pend_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;

  logic            gnt_any;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] scan_idx;

  // A held lock wins outright; otherwise scan from rr_q upward, wrapping at NR_PORTS.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    gnt_o    = '0;
    if (locked_q && req_i[owner_q]) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        scan_idx = IdxW'((32'(rr_q) + i) % NR_PORTS);
        if (!gnt_any && req_i[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
    if (gnt_any) begin
      gnt_o[gnt_idx] = 1'b1;
    end
  end

  assign req_o = |req_i;

  always_comb begin
    we_o   = 1'b0;
    addr_o = '0;
    be_o   = '0;
    data_o = '0;
    user_o = '0;
    for (int unsigned k = 0; k < NR_PORTS; k++) begin
      if (gnt_o[k]) begin
        we_o   = we_i[k];
        addr_o = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        be_o   = be_i[k*BeW +: BeW];
        data_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        user_o = wuser_i[k*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  always_comb begin
    rr_d      = rr_q;
    owner_d   = owner_q;
    locked_d  = 1'b0;
    rd_pend_d = 1'b0;
    rd_idx_d  = rd_idx_q;
    if (gnt_any) begin
      locked_d = lock_i[gnt_idx];
      owner_d  = gnt_idx;
      // Priority only rotates once the owner releases its lock.
      if (!lock_i[gnt_idx]) begin
        rr_d = IdxW'((32'(gnt_idx) + 32'd1) % NR_PORTS);
      end
      if (!we_i[gnt_idx]) begin
        rd_pend_d = 1'b1;
        rd_idx_d  = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      owner_q   <= '0;
      locked_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (rd_pend_q) begin
      rvalid_o[rd_idx_q] = 1'b1;
    end
  end

  assign rdata_o = data_i;
  assign ruser_o = user_i;

endmodule
